// File: rtl/token_pkg.sv
// -----------------------------------------------------------------------------
// token_pkg
// Shared definitions for the serial token repeater:
//   - repeat / pending budget limits and the widths derived from them
//   - controller state encoding
//   - clamp_repeat(): maps a requested repeat factor onto the legal range
// -----------------------------------------------------------------------------
package token_pkg;

  // Largest legal repeat factor; larger requests are clamped down to it.
  localparam int MAX_REPEAT  = 4;
  // Largest allowed pre-decrement pending total before overflow is flagged.
  localparam int MAX_PENDING = 200;

  localparam int REP_W  = $clog2(MAX_REPEAT + 1);
  // Headroom of MAX_REPEAT above the budget so pend + rep can never wrap
  // before the overflow comparison sees it.
  localparam int PEND_W = $clog2(MAX_PENDING + MAX_REPEAT + 1);

  // Repeat factor restored by reset.
  localparam logic [REP_W-1:0] RESET_REPEAT = REP_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  // A factor of zero would silently swallow tokens, so it is promoted to 1.
  function automatic logic [REP_W-1:0] clamp_repeat(input logic [REP_W-1:0] req);
    logic [REP_W-1:0] res;
    if (req == '0) begin
      res = REP_W'(1);
    end else if (req > REP_W'(MAX_REPEAT)) begin
      res = REP_W'(MAX_REPEAT);
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/token_pend_counter.sv
// -----------------------------------------------------------------------------
// token_pend_counter
// Holds the count of output cycles still owed and decides, each cycle, whether
// an output cycle is emitted and whether the budget is exceeded.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : counter active (deasserted while the controller is in ERROR)
//   a             : serial token input
//   rep           : current repeat factor
//   ovf_detect    : pre-decrement total exceeds the budget this cycle
//   emit          : an output cycle is produced this cycle
//   more_pending  : output cycles remain owed after this one
// -----------------------------------------------------------------------------
module token_pend_counter
  import token_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic [REP_W-1:0] rep,
  output logic             ovf_detect,
  output logic             emit,
  output logic             more_pending
);

  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic [PEND_W-1:0] add;
  logic [PEND_W-1:0] total;

  // Total owed including any token arriving now, evaluated at full counter
  // width. On overflow or when nothing is owed the counter returns to zero;
  // otherwise one owed cycle is consumed by this cycle's output.
  always_comb begin
    add          = (en && a) ? {{(PEND_W-REP_W){1'b0}}, rep} : '0;
    total        = pend_q + add;
    ovf_detect   = en && (total > PEND_W'(MAX_PENDING));
    emit         = en && !ovf_detect && (total != '0);
    more_pending = emit && (total != PEND_W'(1));
    pend_d       = '0;
    if (emit) begin
      pend_d = total - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/token_repeat_ctrl.sv
// -----------------------------------------------------------------------------
// token_repeat_ctrl
// Serial token repeater: every '1' on a is replayed rep times on b, with
// consecutive tokens extending the burst without gaps. The repeat factor is
// programmed through a valid/ready port that only accepts while idle, and a
// pending total beyond the budget latches a sticky overflow until reset.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   a           : serial token input (1 = token)
//   cfg_valid   : config request
//   cfg_repeat  : requested repeat factor (0 -> 1, above MAX_REPEAT -> MAX_REPEAT)
//   cfg_ready   : config can be accepted (controller idle)
//   b           : registered repeated token output
//   busy        : output cycles still owed
//   overflow    : sticky budget overflow
// -----------------------------------------------------------------------------
module token_repeat_ctrl
  import token_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             cfg_valid,
  input  logic [REP_W-1:0] cfg_repeat,
  output logic             cfg_ready,
  output logic             b,
  output logic             busy,
  output logic             overflow
);

  state_t           state_q;
  state_t           state_d;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
  logic             b_q;
  logic             b_d;
  logic             cfg_ready_q;
  logic             cfg_ready_d;
  logic             busy_q;
  logic             busy_d;
  logic             overflow_q;
  logic             overflow_d;

  logic             run_en;
  logic             cfg_accept;
  logic             ovf_detect;
  logic             emit;
  logic             more_pending;

  // In ERROR the counter is frozen at zero and tokens are ignored.
  assign run_en = (state_q != ERROR);

  token_pend_counter u_pend (
    .clk          (clk),
    .rst          (rst),
    .en           (run_en),
    .a            (a),
    .rep          (rep_q),
    .ovf_detect   (ovf_detect),
    .emit         (emit),
    .more_pending (more_pending)
  );

  // Next state and next output bit. The counter already folds the incoming
  // token into its decision, so the FSM only classifies the result.
  always_comb begin
    state_d = state_q;
    b_d     = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (ovf_detect) begin
          state_d = ERROR;
        end else if (emit) begin
          b_d     = 1'b1;
          state_d = more_pending ? RUN : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Config handshake. The token seen in the acceptance cycle was already
  // scaled by rep_q above, so the new factor only takes effect next cycle.
  always_comb begin
    cfg_accept = cfg_valid && cfg_ready_q;
    rep_d      = rep_q;
    if (cfg_accept) begin
      rep_d = clamp_repeat(cfg_repeat);
    end
  end

  // Status flags are registered from the next state so they line up with
  // state_q without any decode logic on the output path.
  always_comb begin
    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    overflow_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rep_q       <= RESET_REPEAT;
      b_q         <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rep_q       <= rep_d;
      b_q         <= b_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign b         = b_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/token_repeat_ctrl.md
Name: token_repeat_ctrl

Overview:
Configurable serial token repeater with a controller for the pending-token budget. Every incoming token '1' on the serial input is replayed N times on the serial output, with N programmed at runtime through a valid/ready config port. A small FSM enforces the following:
- reconfiguration only when the pipeline is empty;
- the pending budget limit;
- a sticky overflow error.
It sits between a serial token source and any serial consumer in the sequential-basics datapath.

Parameters:
MAX_REPEAT, 4, largest legal repeat factor; cfg values above it are clamped.
MAX_PENDING, 200, largest allowed value of the pre-decrement total (see Behaviour); exceeding it raises overflow.
REP_W, $clog2(MAX_REPEAT+1), width of cfg_repeat.
PEND_W, $clog2(MAX_PENDING+MAX_REPEAT+1), width of the internal pending counter.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
a  input  1  serial token input; 1 = token.
cfg_valid  input  1  config request.
cfg_repeat  input  REP_W  requested repeat factor.
cfg_ready  output  1  config accepted this cycle when cfg_valid && cfg_ready.
b  output  1  serial repeated token output (registered).
busy  output  1  pending tokens outstanding.
overflow  output  1  sticky budget-overflow error.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: b=0, busy=0, overflow=0, cfg_ready=1, pend=0, rep=2, state=IDLE.
- State: rep register holds the repeat factor; pend counter holds PEND_W bits.
- FSM states:
  - IDLE (pend==0)
  - RUN (pend!=0)
  - ERROR (overflow set)
- Outputs by state:
  - cfg_ready = (state==IDLE).
  - busy = (state==RUN).
  - overflow = (state==ERROR).
  - All three are registered and derived from the state.
- Per cycle outside ERROR:
  - total = pend + (a ? rep : 0).
  - If total > MAX_PENDING: go to ERROR, b<=0, pend<=0.
  - Else if total != 0: b<=1, pend<=total-1, next state RUN if total-1 != 0, else IDLE.
  - Else: b<=0, stay IDLE.
- Latency: b rises 1 cycle after the first token. Each token contributes exactly rep cycles of b=1. Consecutive tokens extend the burst with no gaps.
- Arithmetic: total is computed at PEND_W width. Because of the headroom in PEND_W, no wrap-around is possible before the overflow check.
- Config acceptance:
  - Accepted only in IDLE. rep <= clamp(cfg_repeat), where 0 maps to 1 and values >MAX_REPEAT map to MAX_REPEAT.
  - A token arriving on a in the same cycle as acceptance uses the old rep. The new rep applies from the next cycle.
- Config while not IDLE: cfg_valid in RUN or ERROR is ignored. The requester must hold cfg_valid until cfg_ready.
- ERROR: a and cfg are ignored, b=0, cfg_ready=0. The state is left only by rst.
- Reset mid-burst: rst aborts the burst; b=0 on the next cycle and the pending count is discarded.

Decomposition:
- Package token_pkg:
  - state enum (IDLE, RUN, ERROR);
  - localparams REP_W and PEND_W as functions of MAX_REPEAT/MAX_PENDING;
  - clamp_repeat() function.
- One natural sub-module: token_pend_counter, which holds the pend register, computes total, and raises ovf_detect. Instantiated by token_repeat_ctrl, which owns the FSM, rep register and config handshake.

Test Plan:
1. Reset, then a=1,0,0,1,1,0,0,0 (rep=2) -> b=0,1,1,0,1,1,1,1 then 0; overflow=0; cfg_ready=0 while busy.
2. cfg_valid=1, cfg_repeat=3 in IDLE -> accepted that cycle. Then single a=1 -> b high exactly 3 cycles starting 1 cycle later; busy high 2 cycles.
3. cfg_repeat=0 -> rep=1, so b mirrors a delayed 1 cycle. cfg_repeat=7 with MAX_REPEAT=4 -> a single token yields 4 cycles of b.
4. Budget with rep=2:
   - 199 consecutive a=1 -> b high 398 cycles, no overflow.
   - 200 consecutive a=1 -> total=201 on the 200th token, overflow=1 next cycle, b=0 thereafter, stays set through further a and cfg until rst.
5. cfg_valid asserted mid-burst -> cfg_ready=0 until pend drains. Accepted in the first IDLE cycle. A token on a in that same cycle uses the old rep.
6. rst asserted mid-burst (pend=5) -> next cycle b=0, busy=0, cfg_ready=1, rep=2; a later token gives 2 cycles of b.
